// File: rtl/ysyx_23060236_ifu.sv
// ysyx_23060236_ifu -- instruction fetch unit.
//
// Fetches one 32-bit instruction at a time over an AXI4-Lite read channel.
// The returned word and its PC are held in an output register and handed to
// decode over a valid/ready handshake. The static prediction is always pc+4.
// A mispredict reported by execute (jump_wrong/jump_target) redirects fetch.
// A bus transaction that is already open is never withdrawn. Instead its data
// is squashed when it returns.
//
// Ports:
//   clock, reset               clock, synchronous active-high reset
//   jump_wrong, jump_target    redirect request from execute
//   araddr/arvalid/arready     AXI4-Lite read address channel
//   rdata/rresp/rvalid/rready  AXI4-Lite read data channel
//   inst/pc/inst_err           fetched instruction, its PC, bus-error flag
//   idu_valid/idu_ready        handshake to decode
//
// Optional build macro IFU_PERF_EN adds two internal counters:
//   fetch_cnt       counts accepted decode handshakes
//   fetch_wait_cyc  counts cycles spent in S_AR or S_R
module ysyx_23060236_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_wrong,
  input  logic [31:0] jump_target,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_err,
  output logic        idu_valid,
  input  logic        idu_ready
);

  typedef enum logic [1:0] {S_AR, S_R, S_OUT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_redir_pc, w_redir_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_squash, w_squash_nxt;
  logic        r_inst_err, w_inst_err_nxt;
  logic        r_idu_valid, w_idu_valid_nxt;
  logic        w_idu_hs;

  assign w_idu_hs = r_idu_valid & idu_ready;

  // Gate the bus requests with reset so that nothing is issued while the slave is held in reset.
  assign arvalid   = (r_state == S_AR) && !reset;
  assign rready    = (r_state == S_R)  && !reset;
  assign araddr    = r_fetch_pc;
  assign inst      = r_inst;
  assign pc        = r_pc;
  assign inst_err  = r_inst_err;
  assign idu_valid = r_idu_valid;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_AR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_redir_pc_nxt  = r_redir_pc;
    w_squash_nxt    = r_squash;
    w_inst_nxt      = r_inst;
    w_pc_nxt        = r_pc;
    w_inst_err_nxt  = r_inst_err;
    w_idu_valid_nxt = r_idu_valid;
    case (r_state)
      S_AR: begin
        // Leave the address untouched. The request still goes out, and the
        // redirect is applied when its data is dropped.
        if (jump_wrong) begin
          w_squash_nxt   = 1'b1;
          w_redir_pc_nxt = jump_target;
        end
        if (arready) w_state_nxt = S_R;
      end
      S_R: begin
        if (rvalid) begin
          if (r_squash || jump_wrong) begin
            // A same-cycle redirect is newer than any stored one.
            w_fetch_pc_nxt = jump_wrong ? jump_target : r_redir_pc;
            w_squash_nxt   = 1'b0;
            w_state_nxt    = S_AR;
          end else begin
            w_inst_nxt      = rdata;
            w_pc_nxt        = r_fetch_pc;
            w_inst_err_nxt  = (rresp != 2'b00);
            w_idu_valid_nxt = 1'b1;
            w_state_nxt     = S_OUT;
          end
        end else if (jump_wrong) begin
          w_squash_nxt   = 1'b1;
          w_redir_pc_nxt = jump_target;
        end
      end
      S_OUT: begin
        // A redirect takes priority over the sequential pc+4.
        if (jump_wrong) begin
          w_idu_valid_nxt = 1'b0;
          w_fetch_pc_nxt  = jump_target;
          w_state_nxt     = S_AR;
        end else if (w_idu_hs) begin
          w_idu_valid_nxt = 1'b0;
          w_fetch_pc_nxt  = r_fetch_pc + 32'd4;
          w_state_nxt     = S_AR;
        end
      end
      default: w_state_nxt = S_AR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_redir_pc  <= 32'h0;
      r_squash    <= 1'b0;
      r_inst      <= 32'h0;
      r_pc        <= 32'h0;
      r_inst_err  <= 1'b0;
      r_idu_valid <= 1'b0;
    end else begin
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_redir_pc  <= w_redir_pc_nxt;
      r_squash    <= w_squash_nxt;
      r_inst      <= w_inst_nxt;
      r_pc        <= w_pc_nxt;
      r_inst_err  <= w_inst_err_nxt;
      r_idu_valid <= w_idu_valid_nxt;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] fetch_wait_cyc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt      <= 32'h0;
      fetch_wait_cyc <= 32'h0;
    end else begin
      if (w_idu_hs) fetch_cnt <= fetch_cnt + 32'd1;
      if (r_state != S_OUT) fetch_wait_cyc <= fetch_wait_cyc + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_ysyx_23060236_ifu.sv
// Directed table-driven bench for ysyx_23060236_ifu. Each table row holds the
// bus and decode inputs for one cycle, plus the outputs expected in that
// cycle. Rows are applied on the falling edge and checked 1 ns later.
module tb_ysyx_23060236_ifu;

  logic        clock = 1'b0;
  logic        reset;
  logic        jump_wrong;
  logic [31:0] jump_target;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_err;
  logic        idu_valid;
  logic        idu_ready;

  always #5 clock = ~clock;

  ysyx_23060236_ifu dut (
    .clock(clock), .reset(reset),
    .jump_wrong(jump_wrong), .jump_target(jump_target),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc(pc), .inst_err(inst_err),
    .idu_valid(idu_valid), .idu_ready(idu_ready)
  );

  typedef struct {
    logic        ar, rv;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        jw;
    logic [31:0] jt;
    logic        rdy;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_rr, e_iv;
    logic [31:0] e_inst, e_pc;
    logic        e_err;
  } vec_t;

  localparam int NV = 36;
  vec_t tv [NV];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic ar, logic rv, logic [31:0] rd, logic [1:0] rs,
                              logic jw, logic [31:0] jt, logic rdy,
                              logic e_arv, logic [31:0] e_addr, logic e_rr,
                              logic e_iv, logic [31:0] e_inst, logic [31:0] e_pc,
                              logic e_err);
    vec_t v;
    v.ar = ar; v.rv = rv; v.rd = rd; v.rs = rs; v.jw = jw; v.jt = jt; v.rdy = rdy;
    v.e_arv = e_arv; v.e_addr = e_addr; v.e_rr = e_rr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    arready = v.ar; rvalid = v.rv; rdata = v.rd; rresp = v.rs;
    jump_wrong = v.jw; jump_target = v.jt; idu_ready = v.rdy;
  endtask

`ifdef IFU_PERF_EN
  logic [31:0] cnt_before;
`endif

  initial begin
    // Zero-wait fetch, held output, squashed fetch, handshake+redirect,
    // error response, redirects in S_AR/S_R, PC wrap, same-cycle discard.
    tv[0]  = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h3000_0000,0, 0,0,0,0);
    tv[1]  = mk(0,1,32'h0000_0413,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    for (int i = 2; i <= 6; i++)
      tv[i] = mk(0,0,32'h0,0,0,32'h0,0, 0,0,0, 1,32'h0000_0413,32'h3000_0000,0);
    tv[7]  = mk(0,0,32'h0,0,0,32'h0,1, 0,0,0, 1,32'h0000_0413,32'h3000_0000,0);
    tv[8]  = mk(0,0,32'h0,0,0,32'h0,0, 1,32'h3000_0004,0, 0,0,0,0);
    tv[9]  = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h3000_0004,0, 0,0,0,0);
    tv[10] = mk(0,0,32'h0,0,1,32'h3000_0100,0, 0,0,1, 0,0,0,0);
    tv[11] = mk(0,0,32'h0,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[12] = mk(0,0,32'h0,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[13] = mk(0,1,32'hDEAD_BEEF,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[14] = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h3000_0100,0, 0,0,0,0);
    tv[15] = mk(0,1,32'h1111_1111,2'b10,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[16] = mk(0,0,32'h0,0,0,32'h0,1, 0,0,0, 1,32'h1111_1111,32'h3000_0100,1);
    tv[17] = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h3000_0104,0, 0,0,0,0);
    tv[18] = mk(0,1,32'h2222_2222,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[19] = mk(0,0,32'h0,0,1,32'h3000_0200,1, 0,0,0, 1,32'h2222_2222,32'h3000_0104,0);
    tv[20] = mk(1,0,32'h0,0,1,32'h3000_0300,0, 1,32'h3000_0200,0, 0,0,0,0);
    tv[21] = mk(0,0,32'h0,0,1,32'h3000_0304,0, 0,0,1, 0,0,0,0);
    tv[22] = mk(0,1,32'h3333_3333,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[23] = mk(0,0,32'h0,0,1,32'hFFFF_FFFC,0, 1,32'h3000_0304,0, 0,0,0,0);
    tv[24] = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h3000_0304,0, 0,0,0,0);
    tv[25] = mk(0,1,32'h4444_4444,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[26] = mk(1,0,32'h0,0,0,32'h0,0, 1,32'hFFFF_FFFC,0, 0,0,0,0);
    tv[27] = mk(0,1,32'h5555_5555,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[28] = mk(0,0,32'h0,0,0,32'h0,1, 0,0,0, 1,32'h5555_5555,32'hFFFF_FFFC,0);
    tv[29] = mk(0,0,32'h0,0,0,32'h0,0, 1,32'h0000_0000,0, 0,0,0,0);
    tv[30] = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h0000_0000,0, 0,0,0,0);
    tv[31] = mk(0,1,32'h6666_6666,0,1,32'h0000_0040,0, 0,0,1, 0,0,0,0);
    tv[32] = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h0000_0040,0, 0,0,0,0);
    tv[33] = mk(0,1,32'h0000_0077,0,0,32'h0,0, 0,0,1, 0,0,0,0);
    tv[34] = mk(0,0,32'h0,0,1,32'h0000_0080,0, 0,0,0, 1,32'h0000_0077,32'h0000_0040,0);
    tv[35] = mk(1,0,32'h0,0,0,32'h0,0, 1,32'h0000_0080,0, 0,0,0,0);

    reset = 1'b1;
    drive(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_arvalid",   {31'b0, arvalid},   32'h0);
    chk("rst_rready",    {31'b0, rready},    32'h0);
    chk("rst_idu_valid", {31'b0, idu_valid}, 32'h0);
    chk("rst_inst",      inst,               32'h0);
    chk("rst_pc",        pc,                 32'h0);
    chk("rst_inst_err",  {31'b0, inst_err},  32'h0);
    @(posedge clock);

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      if (i == 0) reset = 1'b0;
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_arvalid", i), {31'b0, arvalid}, {31'b0, tv[i].e_arv});
      if (tv[i].e_arv) chk($sformatf("v%0d_araddr", i), araddr, tv[i].e_addr);
      chk($sformatf("v%0d_rready", i), {31'b0, rready}, {31'b0, tv[i].e_rr});
      chk($sformatf("v%0d_idu_valid", i), {31'b0, idu_valid}, {31'b0, tv[i].e_iv});
      if (tv[i].e_iv) begin
        chk($sformatf("v%0d_inst", i), inst, tv[i].e_inst);
        chk($sformatf("v%0d_pc", i), pc, tv[i].e_pc);
        chk($sformatf("v%0d_inst_err", i), {31'b0, inst_err}, {31'b0, tv[i].e_err});
      end
`ifdef IFU_PERF_EN
      if (i == 28) cnt_before = dut.fetch_cnt;
      if (i == 29) chk("perf_wrap_inc", dut.fetch_cnt, cnt_before + 32'd1);
      if (i == 35) chk("perf_fetch_cnt", dut.fetch_cnt, 32'd4);
`endif
    end

    // Reset during S_R with a response arriving: the response must be ignored.
    @(negedge clock);
    reset = 1'b1; rvalid = 1'b1; rdata = 32'h8888_8888; arready = 1'b0;
    jump_wrong = 1'b0; idu_ready = 1'b0;
    #1;
    chk("midrst_arvalid", {31'b0, arvalid}, 32'h0);
    chk("midrst_rready",  {31'b0, rready},  32'h0);
    @(negedge clock);
    reset = 1'b0; rvalid = 1'b0;
    #1;
    chk("post_rst_arvalid",   {31'b0, arvalid},   32'h1);
    chk("post_rst_araddr",    araddr,             32'h3000_0000);
    chk("post_rst_idu_valid", {31'b0, idu_valid}, 32'h0);
`ifdef IFU_PERF_EN
    chk("post_rst_perf_cnt", dut.fetch_cnt, 32'h0);
`endif
    @(negedge clock); #1;
    chk("post_rst_hold_araddr", araddr,              32'h3000_0000);
    chk("post_rst_hold_rready", {31'b0, rready},     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
